// File: rtl/measure_rx_stats_if.sv
// rtl/measure_rx_stats_if.sv - 64-bit XGMII receive word bundle
interface measure_rx_stats_if;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;

    modport master (output xgmii_rxd, xgmii_rxc);
    modport slave  (input  xgmii_rxd, xgmii_rxc);
endinterface

// File: rtl/measure_rx_stats.sv
// rtl/measure_rx_stats.sv - per-stream RX frame/byte/latency statistics with per-second snapshot bank
module measure_rx_stats #(
    parameter int          NUM_STREAMS = 4,
    parameter int          SID_W       = 4,
    parameter logic [39:0] MAGIC       = 40'h0,
    parameter int          HDR_OFS     = 50,
    parameter int          LAT_W       = 24,
    parameter int          SUM_W       = 40,
    parameter int          CNT_W       = 32
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 sec_oneshot,
    input  logic [31:0]          global_counter,
    measure_rx_stats_if.slave    xgmii,
    input  logic [SID_W-1:0]     rd_stream,
    output logic [CNT_W-1:0]     rd_pkts,
    output logic [CNT_W-1:0]     rd_bytes,
    output logic [LAT_W-1:0]     rd_lat_min,
    output logic [LAT_W-1:0]     rd_lat_max,
    output logic [SUM_W-1:0]     rd_lat_sum,
    output logic [CNT_W-1:0]     rd_lat_cnt,
    output logic [CNT_W-1:0]     all_frames,
    output logic [CNT_W-1:0]     unknown_frames,
    output logic [7:0]           snap_seq
);
    localparam logic [31:0] LAT_MAX = (LAT_W >= 32) ? 32'hffff_ffff : 32'((64'd1 << LAT_W) - 64'd1);

    function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    logic [15:0] pos;
    logic [7:0]  tag_b [10];
    logic [9:0]  seen;
    logic [31:0] rx_time;
    logic        in_frame, frame_end;

    assign in_frame  = xgmii.xgmii_rxc != 8'hff;
    assign frame_end = !in_frame && (pos != 16'd0);

    // Each lane carries byte pos+k; any lane landing inside the 10-byte tag window is latched.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pos     <= 16'd0;
            seen    <= 10'd0;
            rx_time <= 32'd0;
            for (int j = 0; j < 10; j++) tag_b[j] <= 8'h00;
        end else if (in_frame) begin
            pos <= (pos == 16'hfff8) ? pos : pos + 16'd8;
            for (int k = 0; k < 8; k++) begin
                for (int j = 0; j < 10; j++) begin
                    if (pos + 16'(k) == 16'(HDR_OFS + j)) begin
                        tag_b[j] <= xgmii.xgmii_rxd[8*k +: 8];
                        seen[j]  <= 1'b1;
                        if (j == 8) rx_time <= global_counter;
                    end
                end
            end
        end else if (frame_end) begin
            pos  <= 16'd0;
            seen <= 10'd0;
        end
    end

    logic [39:0]      tag_magic;
    logic [31:0]      tag_ts;
    logic [7:0]       tag_sid;
    logic             tag_ok, known;
    logic [31:0]      lat_diff;
    logic [LAT_W-1:0] lat;

    assign tag_magic = {tag_b[0], tag_b[1], tag_b[2], tag_b[3], tag_b[4]};
    assign tag_ts    = {tag_b[5], tag_b[6], tag_b[7], tag_b[8]};
    assign tag_sid   = tag_b[9];
    assign tag_ok    = (&seen) && (tag_magic == MAGIC);
    assign known     = int'(tag_sid) < NUM_STREAMS;
    assign lat_diff  = rx_time - tag_ts;
    assign lat       = (lat_diff > LAT_MAX) ? LAT_MAX[LAT_W-1:0] : lat_diff[LAT_W-1:0];

    logic [CNT_W-1:0] acc_pkts [NUM_STREAMS], acc_bytes [NUM_STREAMS], acc_cnt [NUM_STREAMS];
    logic [LAT_W-1:0] acc_min  [NUM_STREAMS], acc_max   [NUM_STREAMS];
    logic [SUM_W-1:0] acc_sum  [NUM_STREAMS];
    logic [CNT_W-1:0] nx_pkts  [NUM_STREAMS], nx_bytes  [NUM_STREAMS], nx_cnt  [NUM_STREAMS];
    logic [LAT_W-1:0] nx_min   [NUM_STREAMS], nx_max    [NUM_STREAMS];
    logic [SUM_W-1:0] nx_sum   [NUM_STREAMS];
    logic [CNT_W-1:0] snap_pkts[NUM_STREAMS], snap_bytes[NUM_STREAMS], snap_cnt[NUM_STREAMS];
    logic [LAT_W-1:0] snap_min [NUM_STREAMS], snap_max  [NUM_STREAMS];
    logic [SUM_W-1:0] snap_sum [NUM_STREAMS];
    logic [CNT_W-1:0] acc_all, acc_unk, nx_all, nx_unk;

    // A commit coinciding with the snapshot lands on the freshly cleared interval.
    always_comb begin
        nx_all = sec_oneshot ? '0 : acc_all;
        nx_unk = sec_oneshot ? '0 : acc_unk;
        if (frame_end) nx_all = cnt_add(nx_all, CNT_W'(1));
        if (frame_end && tag_ok && !known) nx_unk = cnt_add(nx_unk, CNT_W'(1));
        for (int s = 0; s < NUM_STREAMS; s++) begin
            nx_pkts[s]  = sec_oneshot ? '0 : acc_pkts[s];
            nx_bytes[s] = sec_oneshot ? '0 : acc_bytes[s];
            nx_cnt[s]   = sec_oneshot ? '0 : acc_cnt[s];
            nx_sum[s]   = sec_oneshot ? '0 : acc_sum[s];
            nx_min[s]   = sec_oneshot ? '1 : acc_min[s];
            nx_max[s]   = sec_oneshot ? '0 : acc_max[s];
            if (frame_end && tag_ok && known && int'(tag_sid) == s) begin
                nx_pkts[s]  = cnt_add(nx_pkts[s], CNT_W'(1));
                nx_bytes[s] = cnt_add(nx_bytes[s], CNT_W'(pos));
                nx_cnt[s]   = cnt_add(nx_cnt[s], CNT_W'(1));
                nx_sum[s]   = sum_add(nx_sum[s], SUM_W'(lat));
                if (lat < nx_min[s]) nx_min[s] = lat;
                if (lat > nx_max[s]) nx_max[s] = lat;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            acc_all        <= '0;
            acc_unk        <= '0;
            all_frames     <= '0;
            unknown_frames <= '0;
            snap_seq       <= 8'd0;
            rd_pkts        <= '0;
            rd_bytes       <= '0;
            rd_lat_min     <= '0;
            rd_lat_max     <= '0;
            rd_lat_sum     <= '0;
            rd_lat_cnt     <= '0;
            for (int s = 0; s < NUM_STREAMS; s++) begin
                acc_pkts[s]  <= '0;  snap_pkts[s]  <= '0;
                acc_bytes[s] <= '0;  snap_bytes[s] <= '0;
                acc_cnt[s]   <= '0;  snap_cnt[s]   <= '0;
                acc_sum[s]   <= '0;  snap_sum[s]   <= '0;
                acc_min[s]   <= '1;  snap_min[s]   <= '1;
                acc_max[s]   <= '0;  snap_max[s]   <= '0;
            end
        end else begin
            acc_all   <= nx_all;
            acc_unk   <= nx_unk;
            acc_pkts  <= nx_pkts;
            acc_bytes <= nx_bytes;
            acc_cnt   <= nx_cnt;
            acc_sum   <= nx_sum;
            acc_min   <= nx_min;
            acc_max   <= nx_max;
            if (sec_oneshot) begin
                all_frames     <= acc_all;
                unknown_frames <= acc_unk;
                snap_seq       <= snap_seq + 8'd1;
                snap_pkts      <= acc_pkts;
                snap_bytes     <= acc_bytes;
                snap_cnt       <= acc_cnt;
                snap_sum       <= acc_sum;
                snap_min       <= acc_min;
                snap_max       <= acc_max;
            end
            rd_pkts    <= '0;
            rd_bytes   <= '0;
            rd_lat_min <= '0;
            rd_lat_max <= '0;
            rd_lat_sum <= '0;
            rd_lat_cnt <= '0;
            for (int s = 0; s < NUM_STREAMS; s++) begin
                if (int'(rd_stream) == s) begin
                    rd_pkts    <= snap_pkts[s];
                    rd_bytes   <= snap_bytes[s];
                    rd_lat_min <= snap_min[s];
                    rd_lat_max <= snap_max[s];
                    rd_lat_sum <= snap_sum[s];
                    rd_lat_cnt <= snap_cnt[s];
                end
            end
        end
    end
endmodule
